// File: rtl/fuzzy_defuzz.sv
// Centroid defuzzifier: walks the membership RAM, accumulates sum(mu) and
// sum(i*mu), then restoring-divides to a Q3.3 crisp centroid.
//
// state  | meaning
// IDLE   | waiting for start, rd_addr parked at 0
// ACC    | one RAM entry per cycle, index 0..7
// DIV    | one quotient bit per cycle, MSB first
// DONE   | one-cycle result strobe
module fuzzy_defuzz #(
  parameter int ADDR_W = 3,
  parameter int MU_W   = 6,
  parameter int FRAC_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [MU_W-1:0]          rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W+FRAC_W-1:0] crisp,
  output logic                     empty_err
);

  localparam int DEN_W = MU_W + ADDR_W;
  localparam int NUM_W = MU_W + 2*ADDR_W - 1;
  localparam int PRD_W = MU_W + ADDR_W;
  localparam int Q_W   = ADDR_W + FRAC_W;
  localparam int DVD_W = NUM_W + FRAC_W;
  localparam int DVS_W = DEN_W + Q_W - 1;
  localparam int R_W   = (DVD_W > DVS_W) ? DVD_W : DVS_W;
  localparam int CNT_W = $clog2(Q_W);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] idx;
  logic [DEN_W-1:0]  den;
  logic [NUM_W-1:0]  num;
  logic [R_W-1:0]    rem;
  logic [R_W-1:0]    dvs;
  logic [Q_W-1:0]    quo;
  logic [CNT_W-1:0]  div_cnt;

  logic [PRD_W-1:0]  prod;
  logic [DEN_W-1:0]  den_sum;
  logic [NUM_W-1:0]  num_sum;
  logic              ge;
  logic [Q_W-1:0]    quo_nxt;
  logic              acc_last;
  logic              div_last;

  assign prod     = PRD_W'(idx) * PRD_W'(rd_data);
  assign den_sum  = den + DEN_W'(rd_data);
  assign num_sum  = num + NUM_W'(prod);
  assign ge       = (rem >= dvs);
  assign quo_nxt  = {quo[Q_W-2:0], ge};
  assign acc_last = (idx == '1);
  assign div_last = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)    state_nxt = S_ACC;
      S_ACC:  if (acc_last) state_nxt = S_DIV;
      S_DIV:  if (div_last) state_nxt = S_DONE;
      S_DONE:               state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // rd_addr decodes only registered state, so it is stable all cycle
  always_comb begin
    rd_addr = '0;
    if (state == S_ACC) rd_addr = idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      den       <= '0;
      num       <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      div_cnt   <= '0;
      crisp     <= '0;
      empty_err <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            idx <= '0;
            den <= '0;
            num <= '0;
          end
        end
        S_ACC: begin
          den <= den_sum;
          num <= num_sum;
          idx <= idx + ADDR_W'(1);
          if (acc_last) begin
            // divisor pre-shifted to the quotient MSB, walked right each cycle
            rem     <= R_W'({num_sum, {FRAC_W{1'b0}}});
            dvs     <= R_W'({den_sum, {(Q_W-1){1'b0}}});
            quo     <= '0;
            div_cnt <= CNT_W'(Q_W - 1);
          end
        end
        S_DIV: begin
          if (ge) rem <= rem - dvs;
          quo     <= quo_nxt;
          dvs     <= dvs >> 1;
          div_cnt <= div_cnt - CNT_W'(1);
          if (div_last) begin
            crisp     <= (den == '0) ? '0 : quo_nxt;
            empty_err <= (den == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzy_defuzz.sv
// Directed bench for fuzzy_defuzz: RAM model, expected-result queue filled at
// start and drained at done, with cycle-exact latency checks.
module tb_fuzzy_defuzz;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] rd_addr;
  logic [5:0] rd_data;
  logic       busy;
  logic       done;
  logic [5:0] crisp;
  logic       empty_err;

  logic [5:0] mem [8];

  typedef struct packed {
    logic [5:0] crisp;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [5:0] last_crisp = '0;

  fuzzy_defuzz dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .crisp     (crisp),
    .empty_err (empty_err)
  );

  assign rd_data = mem[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic fill(input logic [5:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  function automatic exp_t model();
    exp_t e;
    int   den;
    int   num;
    den = 0;
    num = 0;
    for (int i = 0; i < 8; i++) begin
      den += int'(mem[i]);
      num += i * int'(mem[i]);
    end
    e.err   = (den == 0);
    e.crisp = (den == 0) ? 6'd0 : 6'((num * 8) / den);
    return e;
  endfunction

  task automatic check_pop(input string tag);
    exp_t e;
    chk($sformatf("%s_sb_nonempty", tag), 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s_crisp", tag), 32'(crisp), 32'(e.crisp));
      chk($sformatf("%s_empty_err", tag), 32'(empty_err), 32'(e.err));
      last_crisp = e.crisp;
    end
  endtask

  // start sampled at the end of cycle T; ACC in T+1..T+8, done at T+15
  task automatic run(input string tag);
    int n;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model());
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("%s_rd_addr%0d", tag, k), 32'(rd_addr), 32'(k));
      chk($sformatf("%s_busy_acc%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s_nodone_acc%0d", tag, k), 32'(done), 32'd0);
    end
    n = 0;
    for (int c = 9; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
    chk($sformatf("%s_latency", tag), 32'(n), 32'd15);
    chk($sformatf("%s_busy_done", tag), 32'(busy), 32'd1);
    check_pop(tag);
    @(negedge clk);
    chk($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    int   seen;
    logic exp_done;

    rst_n = 1'b0;
    start = 1'b0;
    fill(6'd31);
    repeat (2) @(negedge clk);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_crisp", 32'(crisp), 32'd0);
    chk("rst_empty_err", 32'(empty_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("all31");

    fill(6'd0);
    mem[5] = 6'd63;
    run("mu5");

    fill(6'd0);
    mem[0] = 6'd63;
    mem[7] = 6'd63;
    run("mu0_mu7");

    fill(6'd0);
    mem[1] = 6'd10;
    mem[2] = 6'd20;
    run("trunc");

    fill(6'd0);
    run("empty");

    fill(6'd31);
    run("recover");

    // start held high: three back-to-back runs, done every 16 cycles
    fill(6'd0);
    mem[1] = 6'd10;
    mem[2] = 6'd20;
    @(negedge clk);
    start = 1'b1;
    repeat (3) sb.push_back(model());
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c == 48) start = 1'b0;
      exp_done = ((c % 16) == 15);
      chk($sformatf("held_done_c%0d", c), 32'(done), 32'(exp_done));
      if (done === 1'b1) check_pop($sformatf("held_c%0d", c));
      else chk($sformatf("held_crisp_c%0d", c), 32'(crisp), 32'(last_crisp));
    end
    @(negedge clk);
    chk("held_end_busy", 32'(busy), 32'd0);

    // reset asserted in the 4th ACC cycle
    fill(6'd0);
    mem[5] = 6'd63;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_crisp", 32'(crisp), 32'd0);
    chk("midrst_empty_err", 32'(empty_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    last_crisp = '0;
    run("post_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fuzzy_defuzz.md
# fuzzy_defuzz

Centroid defuzzifier that sits directly downstream of the 8-entry × 6-bit fuzzy membership RAM (output-set memory). On `start` it walks the RAM read port over all 8 addresses, accumulates Σmu and Σ(i·mu), and divides them with a sequential restoring divider. It produces a 6-bit crisp output in unsigned Q3.3: the centroid index with 3 fractional bits, range 0..56.

## Interface
- `ADDR_W`, default 3: RAM address width; entries = 2^ADDR_W = 8.
- `MU_W`, default 6: membership value width; matches the RAM data width.
- `FRAC_W`, default 3: fractional bits of `crisp`.
- Only the defaults are required to be correct.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset; one clock, reset asynchronous and active-low.
- `start` in 1: request a defuzzification; sampled only in IDLE.
- `rd_addr` out ADDR_W: drives the RAM read address `RADD`.
- `rd_data` in MU_W: RAM `DOUT`, a combinational read of `rd_addr` in the same cycle.
- `busy` out 1: high while a computation is in progress.
- `done` out 1: one-cycle pulse; `crisp` and `empty_err` are valid from this cycle.
- `crisp` out 6: centroid in Q3.3; holds until the next `done`.
- `empty_err` out 1: set with `done` when Σmu = 0; holds until the next `done`.

## Operation
- FSM states: IDLE → ACC → DIV → DONE → IDLE.
- **IDLE:** `rd_addr` = 0. When `start` = 1, clear the accumulators and the index counter, then go to ACC.
- **ACC:** runs 8 cycles with index k = 0..7 and `rd_addr` = k. At each rising edge:
  - den += `rd_data`
  - num += k·`rd_data`
  - After k = 7, go to DIV.
- **Accumulator widths:**
  - den is 9 bits (max 8·63 = 504).
  - num is 11 bits (max 63·28 = 1764).
  - The dividend is num·8, 14 bits; the scale is 2^FRAC_W.
- **DIV:** always runs exactly 6 cycles of restoring division, one quotient bit per cycle, MSB first.
  - Result is q = floor(num·8 / den), truncated with no rounding.
  - q ≤ 56, so 6 bits never overflow.
- **Zero denominator:** if den = 0, the divider still runs 6 cycles. The forced result is q = 0 with `empty_err` = 1, so latency is fixed.
- **DONE:** lasts one cycle. `crisp` ← q, `empty_err` ← (den == 0), `done` = 1. Then go to IDLE.
- **`start` outside IDLE** (ACC, DIV, DONE): ignored. It is neither queued nor restarted.
- **RAM writes during ACC:** each entry is sampled once, in its own ACC cycle. A write to an address already read does not affect the current result. A write to an address not yet read is seen if it has completed before that address's cycle. Write ordering is the upstream writer's responsibility.
- **Reset values:** state IDLE; `rd_addr` = 0, `busy` = 0, `done` = 0, `crisp` = 0, `empty_err` = 0; accumulators and divider registers = 0.
- **Reset mid-operation:** `rst_n` low in any state aborts immediately to the reset values. No `done` is produced for the aborted run.

## Timing
- `start` is sampled high at the edge that ends IDLE cycle T.
- Cycles T+1..T+8: ACC, with `rd_addr` = 0..7 respectively.
- Cycles T+9..T+14: DIV.
- Cycle T+15: DONE. `done` = 1; new `crisp` and `empty_err` are visible in this cycle.
- `busy` = 1 in cycles T+1..T+15 inclusive, and 0 in IDLE.
- Earliest next accepted `start` is sampled in cycle T+16, giving back-to-back throughput of one result per 16 cycles.
- All outputs are registered except `rd_addr`. `rd_addr` is registered or decoded from the registered index; it must be stable for the full cycle.

## Test plan
- **RAM at power-on contents** (all entries 31), `start` → `done` at T+15 with `crisp` = 28 (3.5), `empty_err` = 0. Check `rd_addr` = 0..7 in T+1..T+8.
- **mu[5] = 63, all others 0** → `crisp` = 40, `empty_err` = 0. Then **mu[0] = mu[7] = 63**, others 0 → `crisp` = 28.
- **mu[1] = 10, mu[2] = 20**, others 0 → `crisp` = 13 (floor of 400/30), confirming truncation.
- **All entries 0** → `done` still at T+15, `crisp` = 0, `empty_err` = 1. A following run with all entries 31 clears `empty_err` and gives `crisp` = 28.
- **`start` held high continuously:**
  - `done` pulses every 16 cycles.
  - `start` pulses during ACC/DIV do not change the result or the timing.
  - `crisp` holds between `done` pulses.
- **`rst_n` asserted in the 4th ACC cycle:** all outputs go to 0 immediately and no `done` appears. After release, a new `start` gives the correct result at T+15.
